// File: rtl/vga_sync_if.sv
// Raster timing bundle between the VGA sync generator and the pixel/animation stage.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, registered
// sync outputs aligned with the coordinates, and a one-clock frame tick.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             p_tick;
  logic             h_wrap;
  logic             hsync_q;
  logic             vsync_q;
  logic             frame_q;

  // Next-state counters; sync registers load from these so they line up with pix_x/pix_y.
  always_comb begin
    p_tick = (div_cnt == DIV_LAST);
    h_wrap = (h_cnt == H_LAST);
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) begin
        v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      frame_q <= 1'b0;
    end else begin
      div_cnt <= p_tick ? '0 : div_cnt + DIV_W'(1);
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      hsync_q <= (h_next >= HS_START && h_next <= HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_q <= (v_next >= VS_START && v_next <= VS_END) ? SYNC_POL : ~SYNC_POL;
      frame_q <= p_tick && h_wrap && (v_cnt == V_LAST);
    end
  end

  assign vga.p_tick     = p_tick;
  assign vga.pix_x      = h_cnt;
  assign vga.pix_y      = v_cnt;
  assign vga.video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.frame_tick = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a shrunken raster (16x9 totals) at CLK_DIV=2 and CLK_DIV=1.
module tb_vga_sync_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 3;   // H_TOTAL 16, hsync x=10..12
  localparam int VD = 4, VF = 1, VS = 2, VB = 2;   // V_TOTAL 9,  vsync y=5..6

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_sync_if v0 ();
  vga_sync_if v1 ();

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .vga(v0.master)
  );

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .vga(v1.master)
  );

  typedef struct {
    int          k;
    logic [24:0] e0;
    logic [24:0] e1;
  } exp_t;

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ft;
  } dir_t;

  exp_t q[$];
  exp_t cur;
  dir_t dir_tab[13];
  int   ft0[$];
  int   ft1[$];
  int   tests = 0;
  int   fails = 0;
  int   k = 0;
  int   cyc = 0;
  logic [24:0] got0, got1;

  // Closed-form raster: k clocks since reset release.
  function automatic logic [24:0] model(int kk, int d, bit pol);
    int ht, vt, p, x, y;
    logic pt, von, ha, va, ft;
    ht  = HD + HF + HS + HB;
    vt  = VD + VF + VS + VB;
    p   = kk / d;
    x   = p % ht;
    y   = (p / ht) % vt;
    pt  = ((kk % d) == d - 1);
    von = (x < HD) && (y < VD);
    ha  = (x >= HD + HF) && (x < HD + HF + HS);
    va  = (y >= VD + VF) && (y < VD + VF + VS);
    ft  = (kk > 0) && ((kk % (d * ht * vt)) == 0);
    return {pt, 10'(x), 10'(y), von, ha ? pol : ~pol, va ? pol : ~pol, ft};
  endfunction

  task automatic push_exp();
    exp_t e;
    e.k  = k;
    e.e0 = model(k, 2, 1'b0);
    e.e1 = model(k, 1, 1'b1);
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) k++;
    push_exp();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expectation per clock, checked on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur  = q.pop_front();
      got0 = {v0.p_tick, v0.pix_x, v0.pix_y, v0.video_on, v0.hsync, v0.vsync, v0.frame_tick};
      got1 = {v1.p_tick, v1.pix_x, v1.pix_y, v1.video_on, v1.hsync, v1.vsync, v1.frame_tick};
      tests++;
      if (got0 !== cur.e0) begin
        fails++;
        $display("FAIL div2_raster k=%0d got=%h exp=%h", cur.k, got0, cur.e0);
      end
      tests++;
      if (got1 !== cur.e1) begin
        fails++;
        $display("FAIL div1_raster k=%0d got=%h exp=%h", cur.k, got1, cur.e1);
      end
      for (int i = 0; i < 13; i++) begin
        if (dir_tab[i].k == cur.k && !reset) begin
          tests++;
          if (v0.pix_x !== dir_tab[i].x || v0.pix_y !== dir_tab[i].y ||
              v0.hsync !== dir_tab[i].hs || v0.vsync !== dir_tab[i].vs ||
              v0.video_on !== dir_tab[i].von || v0.frame_tick !== dir_tab[i].ft) begin
            fails++;
            $display("FAIL directed k=%0d got x=%0d y=%0d hs=%b vs=%b von=%b ft=%b exp x=%0d y=%0d hs=%b vs=%b von=%b ft=%b",
                     cur.k, v0.pix_x, v0.pix_y, v0.hsync, v0.vsync, v0.video_on, v0.frame_tick,
                     dir_tab[i].x, dir_tab[i].y, dir_tab[i].hs, dir_tab[i].vs, dir_tab[i].von, dir_tab[i].ft);
          end
        end
      end
      if (v0.frame_tick) ft0.push_back(cyc);
      if (v1.frame_tick) ft1.push_back(cyc);
    end
  end

  task automatic check_spacing(string name, int ticks[$], int n, int period);
    tests++;
    if (ticks.size() != n) begin
      fails++;
      $display("FAIL %s_count got=%0d exp=%0d", name, ticks.size(), n);
    end else begin
      for (int i = 1; i < n; i++) begin
        tests++;
        if (ticks[i] - ticks[i-1] != period) begin
          fails++;
          $display("FAIL %s_period got=%0d exp=%0d", name, ticks[i] - ticks[i-1], period);
        end
      end
    end
  endtask

  initial begin
    //                k    x      y     hs    vs    von   ft
    dir_tab[0]  = '{  2, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    dir_tab[1]  = '{ 17, 10'd8, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    dir_tab[2]  = '{ 20, 10'd10, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    dir_tab[3]  = '{ 25, 10'd12, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    dir_tab[4]  = '{ 26, 10'd13, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    dir_tab[5]  = '{ 31, 10'd15, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    dir_tab[6]  = '{ 32, 10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    dir_tab[7]  = '{160, 10'd0, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    dir_tab[8]  = '{224, 10'd0, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    dir_tab[9]  = '{287, 10'd15, 10'd8, 1'b1, 1'b1, 1'b0, 1'b0};
    dir_tab[10] = '{288, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    dir_tab[11] = '{289, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    dir_tab[12] = '{576, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (3) step();
    @(negedge clk); #1 reset = 1'b0;

    // Run to x=11, y=5 (both syncs active) and reset asynchronously mid-cycle.
    repeat (182) step();
    @(posedge clk); #1;
    reset = 1'b1;
    k = 0;
    push_exp();
    repeat (3) step();
    ft0.delete();
    ft1.delete();
    @(negedge clk); #1 reset = 1'b0;

    repeat (3 * 288 + 5) step();

    for (int n = 0; n < 5 && q.size() > 0; n++) @(negedge clk);
    @(negedge clk); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end

    check_spacing("frame_div2", ft0, 3, 288);
    check_spacing("frame_div1", ft1, 6, 144);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
